// File: rtl/amo_ctrl_pkg.sv
// Shared definitions for the atomic-op sequencer: funct5 codes, ALU
// control fields and the sequencer state encoding.
package amo_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_STORE,
        S_DONE
    } state_e;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    localparam logic [6:0] OPC_ALU  = 7'b0010011;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLT   = 3'b010;
    localparam logic [2:0] F3_SLTU  = 3'b011;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;

    function automatic logic misaligned(input logic word, input logic [2:0] a);
        return word ? (a[1:0] != 2'b00) : (a != 3'b000);
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/amo_ctrl_if.sv
// Data-memory request/response port shared by the sequencer and the memory.
interface amo_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic        mem_size;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/amo_rsv.sv
// Single LR reservation: granule tag plus valid bit, with snoop invalidation.
module amo_rsv
    import amo_ctrl_pkg::*;
#(
    parameter int RSV_GRAN = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_i,
    input  logic [63:RSV_GRAN] set_tag_i,
    input  logic               clr_i,
    input  logic               snoop_valid_i,
    input  logic [63:RSV_GRAN] snoop_tag_i,
    input  logic [63:RSV_GRAN] chk_tag_i,
    output logic               match_o
);

    logic               vld_q, vld_d;
    logic [63:RSV_GRAN] tag_q, tag_d;

    // The LR fill is applied last so it wins over a same-cycle snoop.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (clr_i || (snoop_valid_i && (snoop_tag_i == tag_q))) vld_d = 1'b0;
        if (set_i) begin
            vld_d = 1'b1;
            tag_d = set_tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    assign match_o = vld_q && (chk_tag_i == tag_q);

endmodule

// File: rtl/amo_ctrl.sv
// RV64A LR/SC/AMO sequencer: load, one ALU cycle, store, then a done pulse
// carrying the rd value back to writeback.
module amo_ctrl
    import amo_ctrl_pkg::*;
#(
    parameter int RSV_GRAN = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        funct5,
    input  logic              word,
    input  logic [63:0]       addr,
    input  logic [63:0]       src,
    output logic              busy,
    output logic              done,
    output logic [63:0]       rd_data,
    output logic              fault,
    amo_ctrl_if.master        mem,
    input  logic              snoop_valid,
    input  logic [63:0]       snoop_addr,
    output logic [63:0]       alu_a,
    output logic [63:0]       alu_b,
    output logic [14:0]       alu_op_ir,
    input  logic [63:0]       alu_out
);

    state_e      state_q, state_d;
    logic [4:0]  f5_q, f5_d;
    logic        word_q, word_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] src_q, src_d;
    logic [63:0] ld_q, ld_d;
    logic [63:0] st_q, st_d;
    logic [63:0] rd_q, rd_d;
    logic        fault_q, fault_d;
    logic        rsv_set, rsv_clr, rsv_match;
    logic [63:0] lval;
    logic [2:0]  f3;
    logic        use_alu;
    logic        unused_snoop;

    assign unused_snoop = ^snoop_addr[RSV_GRAN-1:0];

    amo_rsv #(.RSV_GRAN(RSV_GRAN)) u_rsv (
        .clk           (clk),
        .rst_n         (rst_n),
        .set_i         (rsv_set),
        .set_tag_i     (addr_q[63:RSV_GRAN]),
        .clr_i         (rsv_clr),
        .snoop_valid_i (snoop_valid),
        .snoop_tag_i   (snoop_addr[63:RSV_GRAN]),
        .chk_tag_i     (addr[63:RSV_GRAN]),
        .match_o       (rsv_match)
    );

    assign lval = word_q ? sext32(mem.mem_rdata[31:0]) : mem.mem_rdata;

    // ALU drive lives apart from next-state so alu_out never loops back here.
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_op_ir = '0;
        f3        = F3_ADD;
        use_alu   = 1'b0;
        if (state_q == S_EXEC) begin
            use_alu = 1'b1;
            alu_a   = ld_q;
            alu_b   = src_q;
            case (f5_q)
                F5_ADD: f3 = F3_ADD;
                F5_XOR: f3 = F3_XOR;
                F5_OR:  f3 = F3_OR;
                F5_AND: f3 = F3_AND;
                F5_MIN, F5_MAX: begin
                    f3 = F3_SLT;
                    if (word_q) alu_b = sext32(src_q[31:0]);
                end
                F5_MINU, F5_MAXU: begin
                    f3 = F3_SLTU;
                    if (word_q) begin
                        alu_a = {32'b0, ld_q[31:0]};
                        alu_b = {32'b0, src_q[31:0]};
                    end
                end
                default: use_alu = 1'b0;
            endcase
            if (use_alu) alu_op_ir = {5'b0, f3, OPC_ALU};
            else begin
                alu_a = '0;
                alu_b = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        f5_d    = f5_q;
        word_d  = word_q;
        addr_d  = addr_q;
        src_d   = src_q;
        ld_d    = ld_q;
        st_d    = st_q;
        rd_d    = rd_q;
        fault_d = fault_q;
        rsv_set = 1'b0;
        rsv_clr = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                f5_d    = funct5;
                word_d  = word;
                addr_d  = addr;
                src_d   = src;
                st_d    = src;
                rd_d    = '0;
                fault_d = 1'b0;
                if (misaligned(word, addr[2:0])) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else if (funct5 == F5_SC) begin
                    rsv_clr = 1'b1;
                    if (rsv_match) state_d = S_STORE;
                    else begin
                        rd_d    = 64'd1;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: if (mem.mem_ack) begin
                ld_d = lval;
                rd_d = lval;
                if (f5_q == F5_LR) begin
                    rsv_set = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_STORE;
                case (f5_q)
                    F5_SWAP:                        st_d = src_q;
                    F5_ADD, F5_XOR, F5_OR, F5_AND:  st_d = alu_out;
                    F5_MIN, F5_MINU:                st_d = alu_out[0] ? ld_q : src_q;
                    F5_MAX, F5_MAXU:                st_d = alu_out[0] ? src_q : ld_q;
                    default: begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_STORE: if (mem.mem_ack) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f5_q    <= '0;
            word_q  <= 1'b0;
            addr_q  <= '0;
            src_q   <= '0;
            ld_q    <= '0;
            st_q    <= '0;
            rd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            f5_q    <= f5_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            rd_q    <= rd_d;
            fault_q <= fault_d;
        end
    end

    // Memory strobes decode straight from state so reset drops them at once.
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign rd_data       = done ? rd_q : '0;
    assign fault         = done & fault_q;
    assign mem.mem_req   = (state_q == S_LOAD) || (state_q == S_STORE);
    assign mem.mem_we    = (state_q == S_STORE);
    assign mem.mem_addr  = mem.mem_req ? addr_q : '0;
    assign mem.mem_size  = mem.mem_req & word_q;
    assign mem.mem_wdata = mem.mem_we ? (word_q ? {32'b0, st_q[31:0]} : st_q) : '0;

endmodule
